hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO result path for MULT, MULTU, DIV and DIVU. It sits beside the EX-stage ALU and receives operands and the operation from the decoded instruction. It raises a stall request to hold the pipeline while it iterates one bit per cycle, then pulses the HI/LO write enable with the 64-bit result.

## Interface
- Parameters: none (data width fixed at 32, iteration count fixed at 32)
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start_i  input  1  EX holds a mul/div instruction; level, held while stalled
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- src1_i  input  32  rs operand: multiplicand or dividend
- src2_i  input  32  rt operand: multiplier or divisor
- flush_i  input  1  cancel the in-flight operation (exception/redirect)
- stall_o  output  1  pipeline hold request
- whilo_o  output  1  one-cycle HI/LO write enable
- hi_o  output  32  product[63:32] or remainder
- lo_o  output  32  product[31:0] or quotient

## Operation
- States:
  - IDLE: waits for start_i.
  - BUSY: 5-bit counter, 32 iterations.
  - DONE: presents the result for one cycle.
- IDLE, start_i=1, flush_i=0:
  - Capture op and operands.
  - For signed ops, store |src1| and |src2| plus sign flags. Result sign is sign1^sign2. Remainder sign follows sign1.
  - Go to BUSY with counter=31.
  - Exception: a DIV or DIVU with src2_i==0 goes straight to DONE.
- BUSY, multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- BUSY, divide: restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit trial subtract.
- Counter decrements each BUSY cycle. At 0: apply two's-complement sign fix-up, register hi_o/lo_o, go to DONE.
- DONE: whilo_o=1 unless flush_i. start_i is ignored, because the finishing instruction still drives it. Next state is IDLE.
- Divide by zero: hi_o=src1_i, lo_o=32'hFFFF_FFFF. No iteration.
- MULTU/DIVU: operands are treated as unsigned and no fix-up is applied.
- hi_o/lo_o hold their last result until the next entry into DONE. They are not cleared on IDLE.
- flush_i in IDLE with start_i high: the operation is not accepted.
- flush_i in BUSY: go to IDLE next cycle, hi_o/lo_o unchanged.
- flush_i in DONE: whilo_o is suppressed and the state still returns to IDLE.
- stall_o = (IDLE & start_i & ~flush_i) | BUSY. It is combinational on the IDLE term and low in DONE.
- whilo_o = DONE & ~flush_i.
- MIN_INT/-1 signed divide: quotient wraps to 32'h8000_0000, remainder 0. No trap.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0, hi_o=lo_o=0, stall_o=0, whilo_o=0. This holds for every state, including mid-BUSY. Any in-flight operation is discarded.
- Normal op, start_i first seen in IDLE at cycle 0:
  - stall_o=1 in cycles 0..32.
  - BUSY in cycles 1..32.
  - DONE in cycle 33: whilo_o=1, hi_o/lo_o valid, stall_o=0.
  - Pipeline advances at the end of cycle 33.
- Divide by zero, start at cycle 0: stall_o=1 in cycle 0 only. DONE in cycle 1.
- Back-to-back ops: the next start_i is accepted in the IDLE cycle after DONE (cycle 34). There is no same-cycle restart from DONE.
- Operands are sampled only at acceptance. src1_i/src2_i changes during BUSY are ignored.

## Test plan
- MULT src1=32'hFFFF_FFFD (-3), src2=5 -> cycles 0..32 stall_o=1; cycle 33 whilo_o=1, hi_o=32'hFFFF_FFFF, lo_o=32'hFFFF_FFF1.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> cycle 33 hi_o=32'hFFFF_FFFE, lo_o=32'h0000_0001.
- DIV src1=-7 (32'hFFFF_FFF9), src2=2 -> cycle 33 lo_o=32'hFFFF_FFFD, hi_o=32'hFFFF_FFFF. Then DIVU 100/7 issued back-to-back -> accepted cycle 34; at cycle 67 lo_o=14, hi_o=2.
- DIVU src1=32'h1234_5678, src2=0 -> stall_o=1 cycle 0 only; cycle 1 whilo_o=1, hi_o=32'h1234_5678, lo_o=32'hFFFF_FFFF.
- MULT 6x7 after a prior result (hi=1,lo=2); flush_i=1 at cycle 10 -> IDLE at cycle 11, stall_o=0, whilo_o never asserts, hi_o=1/lo_o=2 held. Separately, flush_i in DONE -> whilo_o=0 that cycle.
- MULT in progress; rst_n=0 at cycle 15 -> next cycle all outputs 0, state IDLE. A fresh MULT 6x7 gives lo_o=42, hi_o=0, 33 cycles after its start.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO result registers.
// Holds the pipeline for 32 single-bit iterations and then pulses the HI/LO write enable.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand conditioning at acceptance
  logic        signed_op;
  logic        sign1, sign2;
  logic [31:0] abs1, abs2;

  always_comb begin
    signed_op = ~op_i[0];
    sign1     = signed_op & src1_i[31];
    sign2     = signed_op & src2_i[31];
    abs1      = sign1 ? (~src1_i + 32'd1) : src1_i;
    abs2      = sign2 ? (~src2_i + 32'd1) : src2_i;
  end

  // One iteration of either datapath. acc_q holds {partial, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide; opnd_q is the multiplicand or divisor.
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // div_diff[32] set means the trial subtract borrowed: restore
    if (div_diff[32]) begin
      div_step = {div_shift[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
    step     = is_div_q ? div_step : mul_step;
    prod_fix = neg_res_q ? (~step + 64'd1) : step;
    quo_fix  = neg_res_q ? (~step[31:0] + 32'd1) : step[31:0];
    rem_fix  = neg_rem_q ? (~step[63:32] + 32'd1) : step[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          if (op_i[1] && (src2_i == 32'd0)) begin
            hi_d    = src1_i;
            lo_d    = 32'hFFFF_FFFF;
            state_d = StDone;
          end else begin
            is_div_d  = op_i[1];
            neg_res_d = sign1 ^ sign2;
            neg_rem_d = sign1;
            opnd_d    = op_i[1] ? abs2 : abs1;
            acc_d     = {32'd0, op_i[1] ? abs1 : abs2};
            cnt_d     = 5'd31;
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[63:32];
              lo_d = prod_fix[31:0];
            end
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // start_i is still driven by the finishing instruction; never restart here
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stall_o = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StBusy);
  assign whilo_o = (state_q == StDone) && !flush_i;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random ops checked
// cycle by cycle against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        stall_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks;
  int fails;
  // Last value expected to be held in HI/LO
  logic [31:0] held_hi;
  logic [31:0] held_lo;

  hilo_muldiv_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .whilo_o (whilo_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    h  = 32'd0;
    l  = 32'd0;
    case (op)
      2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          h  = sr[31:0];
          l  = sq[31:0];
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  // Issue one op at the current cycle (cycle 0). flush_cyc < 0: no flush; otherwise flush_i is
  // raised during that cycle. On normal completion returns in the IDLE cycle after DONE with
  // start_i still high, so the caller may issue back-to-back.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int flush_cyc);
    logic [31:0] mh, ml;
    int lat;
    model(op, a, b, mh, ml);
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    flush_i = (flush_cyc == 0);
    #1;
    checks++;
    if (stall_o !== (flush_cyc != 0) || whilo_o !== 1'b0) begin
      fails++;
      $display("FAIL %s c0: stall=%b whilo=%b, want stall=%b whilo=0", name, stall_o, whilo_o,
               (flush_cyc != 0));
    end
    if (flush_cyc == 0) begin
      tick();
      start_i = 1'b0;
      flush_i = 1'b0;
      #1;
      checks++;
      if (stall_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== held_hi || lo_o !== held_lo) begin
        fails++;
        $display("FAIL %s idle_flush: stall=%b whilo=%b hi=%h lo=%h, want 0 0 %h %h", name,
                 stall_o, whilo_o, hi_o, lo_o, held_hi, held_lo);
      end
      return;
    end
    for (int c = 1; c < lat; c++) begin
      tick();
      src1_i  = $urandom;
      src2_i  = $urandom;
      flush_i = (c == flush_cyc);
      #1;
      checks++;
      if (stall_o !== 1'b1 || whilo_o !== 1'b0) begin
        fails++;
        $display("FAIL %s busy c%0d: stall=%b whilo=%b, want 1 0", name, c, stall_o, whilo_o);
      end
      if (c == flush_cyc) begin
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
          #1;
          checks++;
          if (stall_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== held_hi || lo_o !== held_lo) begin
            fails++;
            $display("FAIL %s after_flush +%0d: stall=%b whilo=%b hi=%h lo=%h, want 0 0 %h %h",
                     name, k, stall_o, whilo_o, hi_o, lo_o, held_hi, held_lo);
          end
          tick();
        end
        return;
      end
    end
    tick();
    flush_i = (flush_cyc == lat);
    #1;
    checks++;
    if (stall_o !== 1'b0 || whilo_o !== (flush_cyc != lat) || hi_o !== mh || lo_o !== ml) begin
      fails++;
      $display("FAIL %s done c%0d: stall=%b whilo=%b hi=%h lo=%h, want 0 %b %h %h", name, lat,
               stall_o, whilo_o, hi_o, lo_o, (flush_cyc != lat), mh, ml);
    end
    held_hi = mh;
    held_lo = ml;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic go_idle(input int n);
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'b00;
    src1_i  = 32'd0;
    src2_i  = 32'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      fails++;
      $display("FAIL reset: stall=%b whilo=%b hi=%h lo=%h, want all 0", stall_o, whilo_o, hi_o,
               lo_o);
    end
    held_hi = 32'd0;
    held_lo = 32'd0;
    tick();
  endtask

  task automatic test_mult();
    do_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, -1);
    go_idle(1);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    go_idle(2);
    do_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, -1);
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    do_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    do_op("divu_100by7", 2'b11, 32'd100, 32'd7, -1);
    do_op("div_7byneg2", 2'b10, 32'd7, 32'hFFFF_FFFE, -1);
    do_op("div_minbyneg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    go_idle(1);
  endtask

  task automatic test_div_zero();
    do_op("divu_by0", 2'b11, 32'h1234_5678, 32'd0, -1);
    do_op("div_by0", 2'b10, 32'h8765_4321, 32'd0, -1);
    go_idle(1);
  endtask

  task automatic test_flush();
    do_op("prior_hi1_lo2", 2'b01, 32'd2, 32'h8000_0001, -1);
    go_idle(1);
    do_op("mult_flush_busy", 2'b00, 32'd6, 32'd7, 10);
    do_op("mult_flush_idle", 2'b00, 32'd6, 32'd7, 0);
    do_op("divu_flush_done", 2'b11, 32'd1000, 32'd33, 33);
    go_idle(1);
    do_op("div0_flush_done", 2'b11, 32'd9, 32'd0, 1);
    go_idle(1);
  endtask

  task automatic test_reset_mid_busy();
    do_op("prior_nonzero", 2'b00, 32'd3, 32'd3, -1);
    start_i = 1'b1;
    op_i    = 2'b00;
    src1_i  = 32'h0000_1234;
    src2_i  = 32'h0000_5678;
    for (int c = 0; c < 15; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    start_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_busy: stall=%b whilo=%b hi=%h lo=%h, want all 0", stall_o,
               whilo_o, hi_o, lo_o);
    end
    held_hi = 32'd0;
    held_lo = 32'd0;
    tick();
    do_op("mult_6x7_after_reset", 2'b00, 32'd6, 32'd7, -1);
    go_idle(1);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      do_op("random", op, a, b, -1);
      if ($urandom_range(0, 1) == 0) go_idle($urandom_range(1, 3));
    end
    go_idle(1);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
